fir_tap_sequencer: RTL and testbench

- Upstream/downstream wrapper around the combinational fixed-point multiplier (FPM); forms one FIR filter output per accepted input sample.
- Holds the sample delay line and the coefficient bank, and presents one tap per cycle on the FPM a/b operand format.
- Takes back the FPM's 11-bit rounded magnitude, restores its sign and accumulates it.
- Sits between the sample source and the filter output consumer.

---
 rtl/fir_tap_sequencer_if.sv | 38 +++
 rtl/fir_tap_sequencer.sv | 134 +++++++++++++
 tb/tb_fir_tap_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / result-out / coefficient / FPM operand bundle
// for fir_tap_sequencer.
interface fir_tap_sequencer_if #(
    parameter int TAPS = 8,
    parameter int ACCW = 16
);
    localparam int AW = $clog2(TAPS);

    logic            in_valid;
    logic            in_ready;
    logic            in_sign;
    logic [15:0]     in_mag;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [31:0]     coef_data;
    logic [31:0]     mult_a;
    logic [31:0]     mult_b;
    logic [10:0]     mult_prod;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;

    modport master (
        output in_valid, in_sign, in_mag,
        output coef_we, coef_addr, coef_data,
        output mult_prod, out_ready,
        input  in_ready, mult_a, mult_b,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sign, in_mag,
        input  coef_we, coef_addr, coef_data,
        input  mult_prod, out_ready,
        output in_ready, mult_a, mult_b,
        output out_valid, out_data
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer around an external fixed-point multiplier.
// Define FIR_SAT_EN for a saturating accumulator (default: wrap).
module fir_tap_sequencer #(
    parameter int TAPS = 8,
    parameter int ACCW = 16
) (
    input logic clk,
    input logic rst_n,
    fir_tap_sequencer_if.slave bus
);
    localparam int AW = $clog2(TAPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t          r_state;
    logic [16:0]     r_dl [TAPS];
    logic [31:0]     r_coef [TAPS];
    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] r_out_data;
    logic [AW-1:0]   r_tap;
    logic [31:0]     r_mult_a;
    logic [31:0]     r_mult_b;
    logic            r_psign;
    logic            r_out_valid;

    logic            w_in_ready;
    logic            w_accept;
    logic [ACCW:0]   w_prod_ext;
    logic [ACCW:0]   w_acc_ext;
    logic [ACCW:0]   w_sum;
    logic [ACCW-1:0] w_acc_next;

    // in_ready is held low while reset is asserted
    assign w_in_ready    = rst_n & (r_state == ST_IDLE);
    assign w_accept      = bus.in_valid & w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.mult_a    = r_mult_a;
    assign bus.mult_b    = r_mult_b;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    // Sign-restore the FPM magnitude and add it one bit wider
    always_comb begin
        w_prod_ext = {{(ACCW + 1 - 11){1'b0}}, bus.mult_prod};
        w_acc_ext  = {r_acc[ACCW-1], r_acc};
        w_sum      = r_psign ? (w_acc_ext - w_prod_ext)
                             : (w_acc_ext + w_prod_ext);
`ifdef FIR_SAT_EN
        if (w_sum[ACCW] != w_sum[ACCW-1]) begin
            w_acc_next = w_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}}
                                     : {1'b0, {(ACCW-1){1'b1}}};
        end else begin
            w_acc_next = w_sum[ACCW-1:0];
        end
`else
        w_acc_next = w_sum[ACCW-1:0];
`endif
    end

    // Coefficient bank (IDLE-only writes) and sample delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                r_dl[k]   <= '0;
                r_coef[k] <= '0;
            end
        end else begin
            if (r_state == ST_IDLE && bus.coef_we) begin
                r_coef[bus.coef_addr] <= bus.coef_data;
            end
            if (w_accept) begin
                r_dl[0] <= {bus.in_sign, bus.in_mag};
                for (int k = 1; k < TAPS; k++) begin
                    r_dl[k] <= r_dl[k-1];
                end
            end
        end
    end

    // Control FSM: operand issue, accumulate, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_tap       <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_psign     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= '0;
                        r_tap   <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_mult_a <= r_coef[r_tap];
                    r_mult_b <= {r_dl[r_tap][16],
                                 r_dl[r_tap][15:0], 15'b0};
                    r_psign  <= r_coef[r_tap][31] ^ r_dl[r_tap][16];
                    if (r_tap != '0) begin
                        r_acc <= w_acc_next;
                    end
                    r_tap <= r_tap + 1'b1;
                    if (r_tap == AW'(TAPS - 1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_acc       <= w_acc_next;
                    r_out_data  <= w_acc_next;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (TAPS=8, ACCW=12)
// with a behavioural FPM model on the operand bus.
module tb_fir_tap_sequencer;
    localparam int TAPS = 8;
    localparam int ACCW = 12;

    typedef struct {
        logic s;
        int   mag;
        int   exp;
        int   hold;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     q[$];
    longint fpm_a, fpm_b, fpm_p;
    vec_t   imp[8];
    int     ovf[8];

    fir_tap_sequencer_if #(.TAPS(TAPS), .ACCW(ACCW)) ifc ();

    fir_tap_sequencer #(.TAPS(TAPS), .ACCW(ACCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FPM: round(|a| * |b| / 10000), 11-bit result
    always_comb begin
        fpm_a = longint'(ifc.mult_a[30:15]) * 10000
              + longint'(ifc.mult_a[14:0]);
        fpm_b = longint'(ifc.mult_b[30:15]);
        fpm_p = (fpm_a * fpm_b + 5000) / 10000;
        ifc.mult_prod = fpm_p[10:0];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wr_coef(input int addr, input logic s, input int frac);
        ifc.coef_we   = 1'b1;
        ifc.coef_addr = 3'(addr);
        ifc.coef_data = {s, 16'd0, 15'(frac)};
        @(negedge clk);
        ifc.coef_we   = 1'b0;
    endtask

    task automatic send(input logic s, input int mag, input int exp);
        int n = 0;
        while (ifc.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", int'(ifc.in_ready), 1);
        ifc.in_valid = 1'b1;
        ifc.in_sign  = s;
        ifc.in_mag   = 16'(mag);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        q.push_back(exp);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int hold);
        int n = 0;
        int held;
        int exp;
        while (ifc.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, cyc - acc_cyc, TAPS + 1);
        held = int'(ifc.out_data);
        for (int i = 0; i < hold; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_sign  = 1'b0;
            ifc.in_mag   = 16'd7;
            @(negedge clk);
            chk({name, "_hold_valid"}, int'(ifc.out_valid), 1);
            chk({name, "_hold_data"}, int'(ifc.out_data), held);
            chk({name, "_hold_in_ready"}, int'(ifc.in_ready), 0);
        end
        ifc.in_valid = 1'b0;
        if (q.size() > 0) begin
            exp = q.pop_front();
            chk(name, int'($signed(ifc.out_data)), exp);
        end else begin
            chk({name, "_scoreboard_empty"}, 0, 1);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk({name, "_valid_drop"}, int'(ifc.out_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            imp[i].s    = 1'b0;
            imp[i].mag  = (i == 0) ? 100 : 0;
            imp[i].exp  = 10 * (i + 1);
            imp[i].hold = (i == 3) ? 5 : 0;
        end
`ifdef FIR_SAT_EN
        ovf = '{2000, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
`else
        ovf = '{2000, -96, 1904, -192, 1808, -288, 1712, -384};
`endif

        ifc.in_valid  = 1'b0;
        ifc.in_sign   = 1'b0;
        ifc.in_mag    = '0;
        ifc.coef_we   = 1'b0;
        ifc.coef_addr = '0;
        ifc.coef_data = '0;
        ifc.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(ifc.in_ready), 0);
        chk("rst_out_valid", int'(ifc.out_valid), 0);
        chk("rst_out_data", int'(ifc.out_data), 0);
        chk("rst_mult_a", int'(ifc.mult_a), 0);
        chk("rst_mult_b", int'(ifc.mult_b), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", int'(ifc.in_ready), 1);
        @(negedge clk);

        for (int k = 0; k < TAPS; k++) wr_coef(k, 1'b0, 1000 * (k + 1));
        for (int i = 0; i < 8; i++) begin
            send(imp[i].s, imp[i].mag, imp[i].exp);
            collect("impulse", imp[i].hold);
        end

        wr_coef(0, 1'b1, 5000);
        for (int k = 1; k < TAPS; k++) wr_coef(k, 1'b0, 0);
        send(1'b1, 200, 100);
        collect("sign_neg_neg", 0);
        send(1'b0, 200, -100);
        collect("sign_neg_pos", 0);

        send(1'b0, 200, -100);
        wr_coef(0, 1'b0, 9999);
        collect("mac_write_ignored", 0);
        wr_coef(0, 1'b0, 9999);
        send(1'b0, 200, 200);
        collect("idle_write_used", 0);

        send(1'b0, 100, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(ifc.out_valid), 0);
        chk("midrst_mult_a", int'(ifc.mult_a), 0);
        chk("midrst_mult_b", int'(ifc.mult_b), 0);
        chk("midrst_in_ready", int'(ifc.in_ready), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_in_ready", int'(ifc.in_ready), 1);
        send(1'b0, 100, 0);
        collect("post_reset_impulse", 0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < TAPS; k++) wr_coef(k, 1'b0, 10000);
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 2000, ovf[i]);
            collect("overflow", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
